qoi_frame_decode_ctrl: RTL and testbench

Sequencer for the QOI RGB444 chunk decoder. It takes 320-byte compressed chunks from the chunk buffer one at a time and drives the decoder's enable and reset. It forwards each decoded 12-bit pixel to the framebuffer write port with a linear address, honouring backpressure, until FRAME_PIXELS pixels have been written. Placement: between chunk buffer, decoder and framebuffer writer.

---
 rtl/qoi_frame_decode_ctrl_if.sv | 32 +++
 rtl/qoi_frame_decode_ctrl.sv | 120 ++++++++++++
 tb/tb_qoi_frame_decode_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qoi_frame_decode_ctrl_if.sv
// Handshake bundle between the QOI frame sequencer and its chunk buffer, decoder and framebuffer writer.
// master = sequencer side, slave = surrounding blocks.
interface qoi_frame_decode_ctrl_if #(
    parameter int ADDR_W = 17
) ();
    logic              start;
    logic              busy;
    logic              frame_done;
    logic              chunk_valid;
    logic              chunk_ack;
    logic              dec_rst_n;
    logic              dec_en;
    logic              dec_done;
    logic [11:0]       dec_rgb;
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] pix_addr;
    logic [11:0]       pix_data;
    logic              overrun;

    modport master (
        input  start, chunk_valid, dec_done, dec_rgb, pix_ready,
        output busy, frame_done, chunk_ack, dec_rst_n, dec_en,
               pix_valid, pix_addr, pix_data, overrun
    );

    modport slave (
        output start, chunk_valid, dec_done, dec_rgb, pix_ready,
        input  busy, frame_done, chunk_ack, dec_rst_n, dec_en,
               pix_valid, pix_addr, pix_data, overrun
    );
endinterface

// File: rtl/qoi_frame_decode_ctrl.sv
// Frame sequencer for the QOI RGB444 chunk decoder: feeds chunks, resets the decoder between them
// and streams pixels to the framebuffer. Optional sticky overrun flag under QOI_OVERRUN_FLAG_EN.
module qoi_frame_decode_ctrl #(
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_W       = 17
) (
    input  logic                          clk,
    input  logic                          rst_n,
    qoi_frame_decode_ctrl_if.master       bus
);
    localparam logic [ADDR_W-1:0] FP = ADDR_W'(FRAME_PIXELS);

    typedef enum logic [2:0] {IDLE, WAIT_CHUNK, DECODE, DRAIN, CLEAR, DONE} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] issued_q, issued_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              start_acc, limit_hit, xfer;
    logic              dec_en, clr_pulse, frame_done, chunk_ack;

    assign start_acc = (state_q == IDLE) && bus.start;
    assign limit_hit = (issued_q == FP);
    assign xfer      = pend_q && bus.pix_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (bus.start) state_d = WAIT_CHUNK;
            WAIT_CHUNK: if (bus.chunk_valid) state_d = DECODE;
            DECODE:     if (bus.dec_done || limit_hit) state_d = DRAIN;
            // The last pixel must leave before the decoder reset wipes dec_rgb.
            DRAIN:      if (!pend_q) state_d = CLEAR;
            CLEAR:      state_d = (addr_q == FP) ? DONE : WAIT_CHUNK;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        dec_en     = 1'b0;
        clr_pulse  = 1'b0;
        frame_done = 1'b0;
        chunk_ack  = 1'b0;
        unique case (state_q)
            DECODE:  dec_en = !bus.dec_done && (issued_q < FP) && (!pend_q || bus.pix_ready);
            CLEAR: begin
                clr_pulse = 1'b1;
                chunk_ack = 1'b1;
            end
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        if (start_acc)              busy_d = 1'b1;
        else if (state_q == DONE)   busy_d = 1'b0;

        pend_d = dec_en || (pend_q && !bus.pix_ready);

        issued_d = issued_q;
        if (start_acc)   issued_d = '0;
        else if (dec_en) issued_d = issued_q + 1'b1;

        addr_d = addr_q;
        if (start_acc) addr_d = '0;
        else if (xfer) addr_d = addr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            pend_q   <= 1'b0;
            issued_q <= '0;
            addr_q   <= '0;
        end else begin
            busy_q   <= busy_d;
            pend_q   <= pend_d;
            issued_q <= issued_d;
            addr_q   <= addr_d;
        end
    end

`ifdef QOI_OVERRUN_FLAG_EN
    logic overrun_q, overrun_d;

    // Surplus pixels: the frame filled before the decoder ran out of chunk bytes.
    always_comb begin
        overrun_d = overrun_q;
        if (start_acc) overrun_d = 1'b0;
        else if (state_q == DECODE && limit_hit && !bus.dec_done) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done;
    assign bus.chunk_ack  = chunk_ack;
    assign bus.dec_en     = dec_en;
    assign bus.dec_rst_n  = rst_n && !clr_pulse;
    assign bus.pix_valid  = pend_q;
    assign bus.pix_addr   = addr_q;
    assign bus.pix_data   = bus.dec_rgb;
endmodule

// File: tb/tb_qoi_frame_decode_ctrl.sv
// Directed bench for qoi_frame_decode_ctrl with FRAME_PIXELS=8: behavioural chunk buffer and
// decoder, transfer monitor, and linear directed steps checked with immediate assertions.
module tb_qoi_frame_decode_ctrl;
    localparam int FP = 8;
    localparam int AW = 4;
`ifdef QOI_OVERRUN_FLAG_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    qoi_frame_decode_ctrl_if #(.ADDR_W(AW)) bus ();

    qoi_frame_decode_ctrl #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Chunk buffer + decoder model: pixel j of chunk c is {c, j+1}.
    int   chunk_len [4];
    int   n_chunks = 0;
    int   ack_base = 0;
    int   ack_cnt  = 0;
    int   dec_idx  = 0;
    int   ci;
    logic cv_en = 1'b1;

    always_comb begin
        ci = ack_cnt - ack_base;
        bus.chunk_valid = cv_en && (ci < n_chunks);
        bus.dec_done    = bus.chunk_valid ? (dec_idx >= chunk_len[ci]) : 1'b0;
    end

    always @(posedge clk) begin
        if (!bus.dec_rst_n) begin
            dec_idx     <= 0;
            bus.dec_rgb <= '0;
        end else if (bus.dec_en) begin
            dec_idx     <= dec_idx + 1;
            bus.dec_rgb <= {4'(ci), 8'(dec_idx + 1)};
        end
        if (bus.chunk_ack) ack_cnt <= ack_cnt + 1;
    end

    // Monitor sampled on the falling edge.
    int          cyc = 0;
    logic [AW-1:0] got_addr [$];
    logic [11:0] got_data [$];
    int          got_cyc  [$];
    int          acks = 0, dones = 0, clr_cnt = 0, viol = 0, stalls = 0;
    int          ack_cyc = 0, done_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_data = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (bus.pix_valid && bus.pix_ready) begin
                got_addr.push_back(bus.pix_addr);
                got_data.push_back(bus.pix_data);
                got_cyc.push_back(cyc);
            end
            if (bus.chunk_ack)  begin acks  <= acks + 1;  ack_cyc  <= cyc; end
            if (bus.frame_done) begin dones <= dones + 1; done_cyc <= cyc; end
            if (!bus.dec_rst_n) clr_cnt <= clr_cnt + 1;
            if (bus.pix_valid && !bus.pix_ready) stalls <= stalls + 1;
            if (bus.pix_valid && !bus.pix_ready && bus.dec_en) viol <= viol + 1;
            if (prev_stall && bus.pix_data !== prev_data) viol <= viol + 1;
        end
        prev_stall <= rst_n && bus.pix_valid && !bus.pix_ready;
        prev_data  <= bus.pix_data;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int l0, input int l1, input int nc);
        chunk_len[0] = l0;
        chunk_len[1] = l1;
        n_chunks     = nc;
        ack_base     = ack_cnt;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input int d0);
        for (int i = 0; i < 300 && dones == d0; i++) tick();
        chk("frame_done_count", dones - d0, 1);
    endtask

    // Expected stream: chunks in order, truncated at the frame limit, addresses 0..FP-1.
    task automatic expect_stream(input int base, input int nc);
        int k = 0;
        int total = 0;
        for (int c = 0; c < nc; c++)
            total += (chunk_len[c] < FP - total) ? chunk_len[c] : FP - total;
        chk("xfer_count", got_addr.size() - base, total);
        for (int c = 0; c < nc; c++) begin
            for (int j = 0; j < chunk_len[c] && k < FP; j++) begin
                if (base + k < got_addr.size()) begin
                    chk("xfer_addr", got_addr[base+k], k);
                    chk("xfer_data", got_data[base+k], {20'd0, 4'(c), 8'(j + 1)});
                end
                k++;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},      bus.busy, 0);
        chk({tag, "_done"},      bus.frame_done, 0);
        chk({tag, "_ack"},       bus.chunk_ack, 0);
        chk({tag, "_dec_en"},    bus.dec_en, 0);
        chk({tag, "_pix_valid"}, bus.pix_valid, 0);
        chk({tag, "_pix_addr"},  bus.pix_addr, 0);
        chk({tag, "_overrun"},   bus.overrun, 0);
        chk({tag, "_dec_rst_n"}, bus.dec_rst_n, 0);
    endtask

    initial begin
        int base, a0, d0, c0, v0, s0, n_en, n_nb;
        logic [3:0] pat;
        bus.start     = 1'b0;
        bus.pix_ready = 1'b1;
        load(0, 0, 0);
        tick(2);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Single chunk of 8 at full rate.
        load(8, 0, 1);
        base = got_addr.size(); a0 = acks; d0 = dones;
        start_pulse();
        chk("busy_after_start", bus.busy, 1);
        run_frame(d0);
        chk("busy_after_done", bus.busy, 0);
        expect_stream(base, 1);
        chk("t1_acks", acks - a0, 1);
        if (got_cyc.size() >= base + 8) chk("t1_back_to_back", got_cyc[base+7] - got_cyc[base], 7);
        chk("t1_done_after_clear", done_cyc - ack_cyc, 1);

        // Two chunks of 5 and 3.
        load(5, 3, 2);
        base = got_addr.size(); a0 = acks; d0 = dones; c0 = clr_cnt;
        start_pulse();
        run_frame(d0);
        expect_stream(base, 2);
        chk("t2_acks", acks - a0, 2);
        chk("t2_dec_rst_cycles", clr_cnt - c0, 2);

        // Backpressure pattern 1,0,0,1.
        load(8, 0, 1);
        base = got_addr.size(); d0 = dones; v0 = viol; s0 = stalls;
        pat = 4'b1001;
        start_pulse();
        for (int i = 0; i < 400 && dones == d0; i++) begin
            bus.pix_ready = pat[i % 4];
            tick();
        end
        bus.pix_ready = 1'b1;
        chk("t3_frame_done_count", dones - d0, 1);
        chk("t3_stalls_seen", stalls - s0 > 0, 1);
        chk("t3_stall_violations", viol - v0, 0);
        expect_stream(base, 1);

        // Chunk with 12 pixels against an 8-pixel frame.
        load(12, 0, 1);
        base = got_addr.size(); a0 = acks; d0 = dones;
        start_pulse();
        run_frame(d0);
        expect_stream(base, 1);
        chk("t4_acks", acks - a0, 1);
        chk("t4_overrun", bus.overrun, EXP_OVR);

        // chunk_valid held off for 20 cycles.
        cv_en = 1'b0;
        load(8, 0, 1);
        base = got_addr.size(); d0 = dones;
        start_pulse();
        chk("t5_overrun_cleared", bus.overrun, 0);
        n_en = 0; n_nb = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.dec_en) n_en++;
            if (!bus.busy)  n_nb++;
        end
        chk("t5_dec_en_while_waiting", n_en, 0);
        chk("t5_busy_low_while_waiting", n_nb, 0);
        cv_en = 1'b1;
        chk("t5_no_dec_en_same_cycle", bus.dec_en, 0);
        tick();
        chk("t5_dec_en_next_cycle", bus.dec_en, 1);
        run_frame(d0);
        expect_stream(base, 1);

        // start while busy, then reset at pixel 3.
        load(8, 0, 1);
        base = got_addr.size();
        start_pulse();
        for (int i = 0; i < 50 && got_addr.size() - base < 1; i++) tick();
        start_pulse();
        chk("t6_busy_held", bus.busy, 1);
        for (int i = 0; i < 50 && got_addr.size() - base < 3; i++) tick();
        chk("t6_pixels_before_reset", got_addr.size() - base >= 3, 1);
        if (got_addr.size() >= base + 3) chk("t6_no_restart", got_addr[base+2], 2);
        a0 = acks;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midreset");
        tick(2);
        rst_n = 1'b1;
        tick();
        chk("t6_no_ack_on_reset", acks - a0, 0);
        load(8, 0, 1);
        base = got_addr.size(); d0 = dones;
        start_pulse();
        run_frame(d0);
        expect_stream(base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
